// File: rtl/sockit_spi_skd.sv
// sockit_spi_skd: stream register slice (skid buffer).
// Registers the forward path (vld/dat) and the backpressure path (rdy)
// so no input reaches any output combinationally. Holds up to two words:
// an output register (obuf/ovld) and one skid register (sbuf/svld).
// Optional transfer counter on cnt_o when SOCKIT_SPI_SKD_CNT_EN is defined.
//
// Handshake: a word moves across a port on a rising clk edge exactly when
// valid and ready are both 1 in that cycle. A source holding valid=1 keeps
// its data stable until ready is seen, and valid never depends on ready.
module sockit_spi_skd #(
    parameter type DT = logic [31:0],
    localparam int DW = $bits(DT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sti_vld_i,
    input  logic [DW-1:0] sti_dat_i,
    output logic          sti_rdy_o,
    output logic          sto_vld_o,
    output logic [DW-1:0] sto_dat_o,
    input  logic          sto_rdy_i,
    output logic [1:0]    dbg_state_o
`ifdef SOCKIT_SPI_SKD_CNT_EN
   ,output logic [31:0]   cnt_o
`endif
);

    // State encoding is {svld, ovld}; 2'b10 cannot be reached.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

    logic          ovld_q, ovld_d;
    logic          svld_q, svld_d;
    logic [DW-1:0] obuf_q, obuf_d;
    logic [DW-1:0] sbuf_q, sbuf_d;
    logic          ti;
    logic          to;

    // Transfers are computed from flop outputs and raw port inputs only.
    assign ti = sti_vld_i & ~svld_q;
    assign to = ovld_q & sto_rdy_i;

    // Next-state selection for the two storage slots.
    always_comb begin
        ovld_d = ovld_q;
        svld_d = svld_q;
        obuf_d = obuf_q;
        sbuf_d = sbuf_q;
        case ({svld_q, ovld_q})
            ST_EMPTY: begin
                if (ti) begin
                    obuf_d = sti_dat_i;
                    ovld_d = 1'b1;
                end
            end
            ST_ONE: begin
                if (ti && to) begin
                    obuf_d = sti_dat_i;
                end else if (ti) begin
                    sbuf_d = sti_dat_i;
                    svld_d = 1'b1;
                end else if (to) begin
                    ovld_d = 1'b0;
                end
            end
            ST_FULL: begin
                // Input is stalled here, so only the output side can move.
                if (to) begin
                    obuf_d = sbuf_q;
                    svld_d = 1'b0;
                end
            end
            default: begin
                ovld_d = 1'b0;
                svld_d = 1'b0;
            end
        endcase
    end

    // Storage registers with synchronous reset clearing both words.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovld_q <= 1'b0;
            svld_q <= 1'b0;
            obuf_q <= '0;
            sbuf_q <= '0;
        end else begin
            ovld_q <= ovld_d;
            svld_q <= svld_d;
            obuf_q <= obuf_d;
            sbuf_q <= sbuf_d;
        end
    end

    assign sto_vld_o   = ovld_q;
    assign sto_dat_o   = obuf_q;
    assign sti_rdy_o   = ~svld_q;
    assign dbg_state_o = {svld_q, ovld_q};

`ifdef SOCKIT_SPI_SKD_CNT_EN
    logic [31:0] cnt_q;

    // Output transfer counter, wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (to) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_sockit_spi_skd.sv
// Bench for sockit_spi_skd: directed vector table, reset/counter sequences,
// and randomized stress of an 8-bit instance against a queue model.
module tb_sockit_spi_skd;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        vld, rdy_o, ovld, ordy;
    logic [31:0] dat, odat;
    logic [1:0]  st;
`ifdef SOCKIT_SPI_SKD_CNT_EN
    logic [31:0] cnt;
`endif

    sockit_spi_skd dut (
        .clk         (clk),
        .rst         (rst),
        .sti_vld_i   (vld),
        .sti_dat_i   (dat),
        .sti_rdy_o   (rdy_o),
        .sto_vld_o   (ovld),
        .sto_dat_o   (odat),
        .sto_rdy_i   (ordy),
        .dbg_state_o (st)
`ifdef SOCKIT_SPI_SKD_CNT_EN
       ,.cnt_o       (cnt)
`endif
    );

    // 8-bit instance for random stress
    logic       vld8, rdy8_o, ovld8, ordy8;
    logic [7:0] dat8, odat8;
    logic [1:0] st8;
`ifdef SOCKIT_SPI_SKD_CNT_EN
    logic [31:0] cnt8;
`endif

    sockit_spi_skd #(.DT(logic [7:0])) dut8 (
        .clk         (clk),
        .rst         (rst),
        .sti_vld_i   (vld8),
        .sti_dat_i   (dat8),
        .sti_rdy_o   (rdy8_o),
        .sto_vld_o   (ovld8),
        .sto_dat_o   (odat8),
        .sto_rdy_i   (ordy8),
        .dbg_state_o (st8)
`ifdef SOCKIT_SPI_SKD_CNT_EN
       ,.cnt_o       (cnt8)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // advance one clock; inputs are changed and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        vld;
        logic [31:0] dat;
        logic        ordy;
        logic        e_ovld;
        logic [31:0] e_odat;
        logic        e_irdy;
    } vec_t;

    vec_t vecs[17];

    // ---------------- scoreboard for random stress ----------------
    logic [7:0] exp_q[$];

    initial begin
        logic [7:0] prev_dat;
        logic       prev_stall;
        logic       ti, to;

        // streaming 0x1..0x8, each seen on sto one cycle after acceptance
        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{1'b1, 32'(i + 1), 1'b1, (i != 0), 32'(i), 1'b1};
        end
        vecs[8]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b1};
        vecs[9]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1};
        // backpressure fill with 0xA, 0xB, 0xC
        vecs[10] = '{1'b1, 32'hA, 1'b0, 1'b0, 32'h0, 1'b1};
        vecs[11] = '{1'b1, 32'hB, 1'b0, 1'b1, 32'hA, 1'b1};
        vecs[12] = '{1'b1, 32'hC, 1'b0, 1'b1, 32'hA, 1'b0};
        vecs[13] = '{1'b1, 32'hC, 1'b0, 1'b1, 32'hA, 1'b0};
        // drain
        vecs[14] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'hA, 1'b0};
        vecs[15] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'hB, 1'b1};
        vecs[16] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1};

        vld = 0; dat = '0; ordy = 0;
        vld8 = 0; dat8 = '0; ordy8 = 0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        chk("rst_sto_vld", 32'(ovld), 32'd0);
        chk("rst_sto_dat", odat, 32'd0);
        chk("rst_sti_rdy", 32'(rdy_o), 32'd1);
        chk("rst_state", 32'(st), 32'd0);
`ifdef SOCKIT_SPI_SKD_CNT_EN
        chk("rst_cnt", cnt, 32'd0);
`endif

        // table-driven directed vectors
        for (int i = 0; i < 17; i++) begin
            vld = vecs[i].vld; dat = vecs[i].dat; ordy = vecs[i].ordy;
            chk($sformatf("vec%0d_sto_vld", i), 32'(ovld), 32'(vecs[i].e_ovld));
            chk($sformatf("vec%0d_sti_rdy", i), 32'(rdy_o), 32'(vecs[i].e_irdy));
            if (vecs[i].e_ovld) chk($sformatf("vec%0d_sto_dat", i), odat, vecs[i].e_odat);
            tick();
        end

        // reset while FULL: stored words are discarded, transfers in the reset cycle ignored
        vld = 1; dat = 32'h11; ordy = 0; tick();
        dat = 32'h22; tick();
        chk("full_state", 32'(st), 32'd3);
        chk("full_sti_rdy", 32'(rdy_o), 32'd0);
        rst = 1; vld = 1; dat = 32'h33; ordy = 1; tick();
        rst = 0; vld = 1; dat = 32'h44; ordy = 0;
        chk("rstfull_sto_vld", 32'(ovld), 32'd0);
        chk("rstfull_sti_rdy", 32'(rdy_o), 32'd1);
        chk("rstfull_state", 32'(st), 32'd0);
`ifdef SOCKIT_SPI_SKD_CNT_EN
        chk("rstfull_cnt", cnt, 32'd0);
`endif
        // first transfer right after reset deasserts
        tick();
        vld = 0; ordy = 1;
        chk("post_rst_sto_vld", 32'(ovld), 32'd1);
        chk("post_rst_sto_dat", odat, 32'h44);
        tick();
        chk("post_rst_empty", 32'(ovld), 32'd0);
        tick();
        chk("post_rst_no_old", 32'(ovld), 32'd0);

`ifdef SOCKIT_SPI_SKD_CNT_EN
        // counter wrap: preload near the top, then three output transfers
        ordy = 0; vld = 0;
        force dut.cnt_q = 32'hFFFF_FFFE;
        #2;
        release dut.cnt_q;
        tick();
        chk("cnt_preload", cnt, 32'hFFFF_FFFE);
        ordy = 1;
        for (int i = 0; i < 3; i++) begin
            vld = 1; dat = 32'h50 + 32'(i); tick();
        end
        vld = 0; tick(); tick();
        chk("cnt_wrap", cnt, 32'h1);
`endif
        vld = 0; ordy = 0;

        // random stress on the 8-bit instance
        rst = 1; tick(); rst = 0;
        exp_q.delete();
        prev_stall = 0;
        prev_dat   = '0;
        for (int c = 0; c < 10000; c++) begin
            vld8  = ($urandom_range(0, 3) != 0);
            dat8  = 8'($urandom);
            ordy8 = ($urandom_range(0, 2) != 0);
            chk("rnd_sto_vld", 32'(ovld8), 32'(exp_q.size() > 0));
            chk("rnd_sti_rdy", 32'(rdy8_o), 32'(exp_q.size() < 2));
            if (exp_q.size() > 0) chk("rnd_sto_dat", 32'(odat8), 32'(exp_q[0]));
            if (prev_stall) chk("rnd_stall_stable", 32'(odat8), 32'(prev_dat));
            ti = vld8 && (exp_q.size() < 2);
            to = ordy8 && (exp_q.size() > 0);
            prev_stall = (exp_q.size() > 0) && !ordy8;
            prev_dat   = odat8;
            tick();
            if (to) void'(exp_q.pop_front());
            if (ti) exp_q.push_back(dat8);
        end
        vld8 = 0; ordy8 = 1;
        for (int i = 0; i < 3; i++) tick();
        chk("rnd_final_empty", 32'(ovld8), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sockit_spi_skd.md
SOCKIT_SPI_SKD -- requirements
Module: sockit_spi_skd

Stream register slice (skid buffer) that registers both the forward path (vld/dat) and the backpressure path (rdy) of a sockit_spi_if stream.

Interface
REQ-001 Parameter: DT, logic [32-1:0], stream data type; DW = $bits(DT) throughout.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 sti.vld  input  1  input stream valid.
REQ-005 sti.dat  input  DW  input stream data.
REQ-006 sti.rdy  output  1  input stream ready, driven directly from a flop.
REQ-007 sto.vld  output  1  output stream valid, driven directly from a flop.
REQ-008 sto.dat  output  DW  output stream data, driven directly from a flop.
REQ-009 sto.rdy  input  1  output stream ready (downstream backpressure).
REQ-010 cnt  output  32  transfer counter; present only with SOCKIT_SPI_SKD_CNT_EN.

Function
REQ-011 Transfer definitions: input transfer (ti) = sti.vld & sti.rdy; output transfer (to) = sto.vld & sto.rdy.
REQ-012 Storage: output register (obuf, flag ovld) plus one skid register (sbuf, flag svld); capacity 2 words.
REQ-013 State = {svld, ovld}: EMPTY (0,0), ONE (0,1), FULL (1,1); (1,0) is unreachable.
REQ-014 sto.vld = ovld; sto.dat = obuf; sti.rdy = ~svld; no combinational path from any input to any output.
REQ-015 EMPTY: ti -> obuf <= sti.dat, go to ONE; else stay in EMPTY.
REQ-016 ONE, ti & to -> obuf <= sti.dat, stay in ONE.
REQ-017 ONE, ti only -> sbuf <= sti.dat, go to FULL.
REQ-018 ONE, to only -> go to EMPTY.
REQ-019 ONE, neither -> hold.
REQ-020 FULL (sti.rdy=0, so no ti): to -> obuf <= sbuf, go to ONE; else hold.
REQ-021 Latency: word accepted in cycle N is presented on sto in cycle N+1 when the slice is EMPTY, or when it is ONE and to occurs in the same cycle.
REQ-022 Throughput: one word per cycle sustained while sto.rdy=1.
REQ-023 Words leave in acceptance order; none are dropped or duplicated.
REQ-024 sto.dat stays stable while sto.vld=1 & sto.rdy=0.
REQ-025 sto.rdy may toggle every cycle; sti.vld/sti.dat are ignored when sti.rdy=0.

Reset
REQ-026 On rst=1 at a clock edge: ovld=0, svld=0, obuf=0, sbuf=0, giving sto.vld=0, sto.dat=0, sti.rdy=1, cnt=0.
REQ-027 Reset mid-operation discards both stored words; ti/to in the reset cycle have no effect.
REQ-028 First transfer is possible in the first cycle after rst deasserts.

Configuration
REQ-029 Macro SOCKIT_SPI_SKD_CNT_EN defined: cnt port exists, increments by 1 on every to, wraps 0xFFFFFFFF -> 0, resets to 0.
REQ-030 Macro SOCKIT_SPI_SKD_CNT_EN undefined: no cnt port and no counter logic; all other behaviour is identical.

Verification
REQ-031 Streaming: sto.rdy=1, words 0x1..0x8 presented back-to-back -> same 8 words on sto, one per cycle, each 1 cycle after acceptance; sti.rdy stays 1.
REQ-032 Backpressure fill: sto.rdy=0, send 0xA, 0xB, 0xC -> 0xA and 0xB accepted, sti.rdy=0 from the cycle after 0xB; 0xC held; sto.dat=0xA stable.
REQ-033 Drain: from FULL (0xA, 0xB), sto.rdy=1 -> 0xA then 0xB out on consecutive cycles; sti.rdy returns to 1 the cycle after 0xA leaves.
REQ-034 Random stress: random sti.vld and sto.rdy for 10000 cycles with DT = logic [8-1:0] -> scoreboard order and data match; no output changes while stalled.
REQ-035 Reset in FULL: rst pulsed for 1 cycle -> next cycle sto.vld=0, sti.rdy=1, cnt=0; old words never appear on sto.
REQ-036 Counter (SOCKIT_SPI_SKD_CNT_EN): preload cnt=0xFFFFFFFE via force, 3 output transfers -> cnt=0x1.
